// File: rtl/hdmi_fb_fetch_if.sv
// Memory read port plus pixel FIFO write side of the framebuffer fetch controller.
// Handshake: rd_req stays high with rd_addr/rd_len stable until the cycle rd_ack is 1;
// after that, rd_len beats follow, each marked by rd_data_valid.
interface hdmi_fb_fetch_if #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 5,
  parameter int LVL_W  = 9
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [23:0]       rd_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_flush;
  logic              fifo_wr_en;
  logic [23:0]       fifo_wr_data;

  modport master (
    output rd_req, rd_addr, rd_len, fifo_flush, fifo_wr_en, fifo_wr_data,
    input  rd_ack, rd_data_valid, rd_data, fifo_level
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, fifo_flush, fifo_wr_en, fifo_wr_data,
    output rd_ack, rd_data_valid, rd_data, fifo_level
  );
endinterface

// File: rtl/hdmi_fb_fetch_ctrl.sv
// Frame-aligned framebuffer fetch: flushes the pixel FIFO on each vsync rise,
// then streams the frame in bursts gated by free FIFO space.
module hdmi_fb_fetch_ctrl #(
  parameter int H_PIX      = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             video_vs,
  hdmi_fb_fetch_if.master  bus,
  output logic             frame_done,
  output logic [7:0]       resync_err,
  output logic [2:0]       dbg_state
);

  localparam int FRAME_PIX = H_PIX * V_LINES;
  localparam int REM_W     = $clog2(FRAME_PIX + 1);
  localparam int LEN_W     = $clog2(BURST_LEN) + 1;
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [LVL_W-1:0] SPACE_TH  = LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [REM_W-1:0] FRAME_REM = REM_W'(FRAME_PIX);
  localparam logic [REM_W-1:0] BURST_REM = REM_W'(BURST_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              vs_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              wr_en_q, wr_en_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              pend_vs_q, pend_vs_d;
  logic [7:0]        resync_q, resync_d;

  logic             vs_rise;
  logic             last_beat;
  logic             abort;
  logic [REM_W-1:0] rem_after;

  assign vs_rise   = video_vs & ~vs_q;
  assign last_beat = bus.rd_data_valid && ((beat_q + LEN_W'(1)) == rd_len_q);
  assign rem_after = rem_q - REM_W'(rd_len_q);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    pend_vs_d = pend_vs_q;
    resync_d  = resync_q;
    abort     = 1'b0;
    wr_en_d   = (state_q == S_RECV) && bus.rd_data_valid;
    wr_data_d = bus.rd_data_valid ? bus.rd_data : wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (enable && vs_rise) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        rd_addr_d = FB_BASE;
        rem_d     = FRAME_REM;
        pend_vs_d = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (vs_rise) begin
          abort   = 1'b1;
          state_d = S_FLUSH;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (bus.fifo_level <= SPACE_TH) begin
          rd_len_d = (rem_q < BURST_REM) ? LEN_W'(rem_q) : LEN_W'(BURST_LEN);
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // Once acked the burst belongs to memory; an abort must drain it first.
        if (bus.rd_ack) begin
          beat_d  = '0;
          abort   = vs_rise;
          state_d = vs_rise ? S_DRAIN : S_RECV;
        end else if (vs_rise) begin
          abort   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_RECV: begin
        if (last_beat) begin
          rd_addr_d = rd_addr_q + ADDR_W'(rd_len_q);
          rem_d     = rem_after;
          if (rem_after == '0) begin
            done_d    = 1'b1;
            pend_vs_d = vs_rise;
            state_d   = S_END;
          end else if (vs_rise) begin
            abort   = 1'b1;
            state_d = S_FLUSH;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          if (bus.rd_data_valid) beat_d = beat_q + LEN_W'(1);
          if (vs_rise) begin
            abort   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (last_beat) state_d = S_FLUSH;
        else if (bus.rd_data_valid) beat_d = beat_q + LEN_W'(1);
      end
      S_END: begin
        // A vsync that landed on the final beat is honoured here, one cycle late.
        if (vs_rise || pend_vs_q) begin
          pend_vs_d = 1'b0;
          state_d   = enable ? S_FLUSH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (resync_q != 8'hFF)) resync_d = resync_q + 8'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      pend_vs_q <= 1'b0;
      resync_q  <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= video_vs;
      rd_addr_q <= rd_addr_d;
      rd_len_q  <= rd_len_d;
      rem_q     <= rem_d;
      beat_q    <= beat_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      pend_vs_q <= pend_vs_d;
      resync_q  <= resync_d;
    end
  end

  assign bus.rd_req       = (state_q == S_REQ);
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_len       = rd_len_q;
  assign bus.fifo_flush   = (state_q == S_FLUSH);
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign frame_done       = done_q;
  assign resync_err       = resync_q;
  assign dbg_state        = state_q;

endmodule
